instr_encoder: RTL
==================

# instr_encoder

Instruction-memory writer for the LEGv8 single-cycle core; it is the producer-side counterpart of the main control decoder. It accepts symbolic instructions (operation kind plus register/immediate fields) over a valid/ready handshake, encodes them into 32-bit R-format or D-format machine words, and buffers them in a small FIFO. It writes the words sequentially into instruction memory from a base address, and is used by the program loader and the self-checking benches.

## Interface
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; IDLE/DONE → RUN, reloads address, clears flags
- finish  in  1  pulse; RUN → DRAIN (no more input accepted)
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept
- in_op  in  3  0 LDUR, 1 STUR, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6–7 illegal
- in_rd  in  5  Rd (R-format) / Rt (D-format)
- in_rn  in  5  Rn
- in_rm  in  5  Rm (R-format only)
- in_imm  in  9  DT_address (D-format only)
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  high in DONE
- err  out  1  sticky: illegal op was received
- wrap  out  1  sticky: address wrapped to 0
- words_written  out  ADDR_W+1  count of completed writes since `start`

## Operation
- Opcodes [31:21]: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
- R-format: {opcode, Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0]}. D-format (LDUR/STUR): {opcode, DT_address[20:12], op2[11:10]=00, Rn[9:5], Rt[4:0]}.
- States: IDLE → (start) RUN → (finish) DRAIN → (FIFO empty, no write pending) DONE → (start) RUN. start in RUN/DRAIN ignored; finish outside RUN ignored; start+finish same cycle in IDLE/DONE: start wins.
- in_ready = (state==RUN) && FIFO not full. Handshake completes on in_valid && in_ready.
- Illegal op: consumed, nothing pushed, err set.
- Write side (RUN/DRAIN): imem_we=1 while FIFO non-empty; imem_addr/imem_wdata hold stable until imem_ready; on imem_we && imem_ready → pop, addr+1, words_written+1.
- Address wraps 2^ADDR_W−1 → 0, sets wrap; writing continues.
- start clears err, wrap, words_written, done; loads addr=BASE_ADDR.

## Timing
- Reset: state IDLE, FIFO empty, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, err 0, wrap 0, words_written 0.
- Accept at edge N → word in FIFO, imem_we=1 in cycle N+1 (latency 1). Throughput 1 word/cycle with imem_ready held high.
- Push and pop in the same cycle allowed; occupancy unchanged. Full is judged on registered occupancy (no same-cycle pass-through on full).
- done asserts the cycle after the last write completes in DRAIN.
- rst mid-operation discards FIFO contents and any pending write; no partial write is completed.

## Structure
- Shared package legv8_pkg: 11-bit opcode constants (shared with the control decoder), op-kind enum, field bit positions, encode function.
- One sub-module: sync_fifo (parameters WIDTH=32, DEPTH=FIFO_DEPTH; push/pop/full/empty/count).

## Test plan
- start; ADD rd=1 rn=2 rm=3 with imem_ready=1 → one write, addr 0, data 0x8B030041, next cycle after accept.
- LDUR rt=5 rn=6 imm=8, then STUR rt=7 rn=8 imm=0 → data 0xF84080C5 at addr 0, 0xF8000107 at addr 1.
- imem_ready=0 while 6 instructions offered → exactly 4 accepted, in_ready drops; release ready → 4 writes in order, addr/data stable during stall.
- in_op=6 between two ADDs → err=1, words_written=2, addresses contiguous 0,1.
- BASE_ADDR=254, 3 instructions, finish → addrs 254,255,0, wrap=1, done=1 after last write.
- rst asserted with 3 words queued → next cycle imem_we=0, in_ready=0, all flags 0; later start resumes at BASE_ADDR.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode constants, operation kinds and the
// instruction-word encoder used by the loader and the control decoder.
package legv8_pkg;

  localparam int OPC_W   = 11;
  localparam int REG_W   = 5;
  localparam int DT_W    = 9;
  localparam int SHAMT_W = 6;
  localparam int OP2_W   = 2;

  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;

  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_ORR  = 3'd5
  } op_kind_e;

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [DT_W-1:0]  dt_addr_t;

  function automatic logic op_legal(logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic is_dformat(op_kind_e k);
    return (k == OP_LDUR) || (k == OP_STUR);
  endfunction

  function automatic logic [OPC_W-1:0] opcode_of(op_kind_e k);
    logic [OPC_W-1:0] opc;
    case (k)
      OP_LDUR: opc = OPC_LDUR;
      OP_STUR: opc = OPC_STUR;
      OP_ADD:  opc = OPC_ADD;
      OP_SUB:  opc = OPC_SUB;
      OP_AND:  opc = OPC_AND;
      OP_ORR:  opc = OPC_ORR;
      default: opc = '0;
    endcase
    return opc;
  endfunction

  // Illegal kinds encode to zero; callers are expected to drop them.
  function automatic logic [31:0] encode(logic [2:0] op, reg_idx_t rd, reg_idx_t rn,
                                         reg_idx_t rm, dt_addr_t imm);
    op_kind_e    k;
    logic [31:0] w;
    k = op_kind_e'(op);
    w = '0;
    if (op_legal(op)) begin
      if (is_dformat(k))
        w = {opcode_of(k), imm, {OP2_W{1'b0}}, rn, rd};
      else
        w = {opcode_of(k), rm, {SHAMT_W{1'b0}}, rn, rd};
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push is ignored when full and
// pop when empty, so callers may drive both without extra gating.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes symbolic LEGv8 instructions, buffers them and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [8:0]        in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic              wrap,
  output logic [ADDR_W:0]   words_written
);

  import legv8_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          active;
  logic          accept;
  logic          legal;
  logic          push;
  logic          wr_done;
  logic          start_ok;
  logic          drained;
  logic [31:0]   enc_word;
  logic [31:0]   fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign in_ready = (state == S_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign legal    = op_legal(in_op);
  assign push     = accept && legal;
  assign enc_word = encode(in_op, in_rd, in_rn, in_rm, in_imm);

  assign imem_we    = active && !fifo_empty;
  assign imem_wdata = imem_we ? fifo_rdata : 32'd0;
  assign wr_done    = imem_we && imem_ready;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign done     = (state == S_DONE);

  // Leave DRAIN in the same cycle the final word is accepted by memory.
  assign drained = fifo_empty || ((fifo_count == CW'(1)) && wr_done);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc_word),
    .pop   (wr_done),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_ok) state_nxt = S_RUN;
      S_RUN:          if (finish)   state_nxt = S_DRAIN;
      S_DRAIN:        if (drained)  state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      imem_addr     <= '0;
      err           <= 1'b0;
      wrap          <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        imem_addr     <= ADDR_W'(BASE_ADDR);
        err           <= 1'b0;
        wrap          <= 1'b0;
        words_written <= '0;
      end else begin
        if (accept && !legal) err <= 1'b1;
        if (wr_done) begin
          imem_addr     <= imem_addr + 1'b1;
          words_written <= words_written + 1'b1;
          if (&imem_addr) wrap <= 1'b1;
        end
      end
    end
  end

endmodule
